// File: rtl/alu_issue_unit.sv
// alu_issue_unit -- decode/issue front end for an external LR35902 ALU.
//
// Accepts opcode bytes on a valid/ready stream and decodes the ALU-class
// instructions: group-1 ops (80-BF and the d8 forms), the accumulator
// ops (RLCA..CCF), ADD HL,rr, and the whole CB page. It holds the
// architectural A/F/BC/DE/HL registers, fetches operands (including (HL)
// over a memory handshake), drives the ALU and commits its result.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_data      opcode/operand byte stream; in_ready accepts it
//   sp_in                 SP value, used only by ADD HL,SP
//   mem_req/we/addr/wdata memory request, held until mem_ack; addr is HL
//   mem_ack/mem_rdata     request completion and read data
//   alu_op/x/y/fin        ALU operation, operands and flag input (F[7:4])
//   alu_o/alu_fout        ALU result and flags {Z,N,H,C}
//   done                  one-cycle pulse after an instruction commits
//   illegal               one-cycle pulse after a non-ALU byte is dropped
//   trap                  sticky illegal trap (optional feature)
//   reg_af..reg_hl        architectural register views
//
// Build option
//   ALU_ISSUE_ILLEGAL_TRAP_EN  when defined, an illegal byte also sets
//                              trap and stalls in_ready until reset.

module alu_issue_unit #(
    parameter logic [15:0] RESET_AF = 16'h01B0,
    parameter logic [15:0] RESET_BC = 16'h0013,
    parameter logic [15:0] RESET_DE = 16'h00D8,
    parameter logic [15:0] RESET_HL = 16'h014D
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    input  logic [15:0] sp_in,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    output logic [7:0]  alu_op,
    output logic [15:0] alu_x,
    output logic [15:0] alu_y,
    output logic [3:0]  alu_fin,
    input  logic [15:0] alu_o,
    input  logic [3:0]  alu_fout,
    output logic        done,
    output logic        illegal,
    output logic        trap,
    output logic [15:0] reg_af,
    output logic [15:0] reg_bc,
    output logic [15:0] reg_de,
    output logic [15:0] reg_hl
);

    typedef enum logic [2:0] {S_IDLE, S_PREFIX, S_IMM, S_MEMRD, S_EXEC, S_MEMWR} state_t;
    typedef enum logic [1:0] {K_G1, K_ACC, K_ADD16, K_CB} kind_t;

    localparam logic [7:0] OP_ADD16 = 8'h20;
    localparam logic [2:0] IDX_HL   = 3'd6;
    localparam logic [2:0] IDX_A    = 3'd7;

    state_t      state_q;
    kind_t       kind_q;
    logic [2:0]  src_q;
    logic [7:0]  op_q, wdata_q;
    logic [15:0] x_q, y_q;
    logic [7:0]  a_q, b_q, c_q, d_q, e_q, h_q, l_q;
    logic [3:0]  f_q;
    logic        done_q, illegal_q, trap_w;

    // Register file view indexed by the 3-bit operand field; slot 6 is (HL)
    // and never read from here.
    logic [7:0][7:0] rf_view;
    assign rf_view = {a_q, 8'h00, l_q, h_q, e_q, d_q, c_q, b_q};

    logic [15:0] hl_w;
    assign hl_w = {h_q, l_q};

    assign in_ready = (state_q == S_IDLE || state_q == S_PREFIX || state_q == S_IMM) && !trap_w;

    logic accept;
    assign accept = in_valid && in_ready;

    // ---------------- byte decode (IDLE and PREFIX) ----------------
    kind_t      dec_kind;
    logic [7:0] dec_op;
    state_t     dec_next;
    logic       dec_ill;

    always_comb begin
        dec_kind = K_G1;
        dec_op   = 8'h00;
        dec_next = S_IDLE;
        dec_ill  = 1'b0;
        if (state_q == S_PREFIX) begin
            dec_kind = K_CB;
            if (in_data[7:6] == 2'b00) begin
                case (in_data[5:3])
                    3'd0: dec_op = 8'h10;
                    3'd1: dec_op = 8'h11;
                    3'd2: dec_op = 8'h12;
                    3'd3: dec_op = 8'h13;
                    3'd4: dec_op = 8'h24;
                    3'd5: dec_op = 8'h25;
                    3'd6: dec_op = 8'h27;
                    default: dec_op = 8'h26;
                endcase
            end else begin
                // BIT/RES/SET -> 3x/4x/5x
                dec_op = {({2'b00, in_data[7:6]} + 4'd2), 1'b0, in_data[5:3]};
            end
            dec_next = (in_data[2:0] == IDX_HL) ? S_MEMRD : S_EXEC;
        end else if (in_data[7:6] == 2'b10) begin
            dec_op   = {5'd0, in_data[5:3]};
            dec_next = (in_data[2:0] == IDX_HL) ? S_MEMRD : S_EXEC;
        end else if (in_data[7:6] == 2'b11 && in_data[2:0] == 3'b110) begin
            dec_op   = {5'd0, in_data[5:3]};
            dec_next = S_IMM;
        end else if (in_data[7:6] == 2'b00 && in_data[2:0] == 3'b111) begin
            dec_kind = K_ACC;
            dec_op   = {5'b00010, in_data[5:3]};
            dec_next = S_EXEC;
        end else if (in_data[7:6] == 2'b00 && in_data[3:0] == 4'h9) begin
            dec_kind = K_ADD16;
            dec_op   = OP_ADD16;
            dec_next = S_EXEC;
        end else if (in_data == 8'hCB) begin
            dec_next = S_PREFIX;
        end else begin
            dec_ill  = 1'b1;
        end
    end

    // ---------------- operands loaded on entry to EXEC ----------------
    kind_t       kind_sel;
    logic [7:0]  opnd;
    logic [15:0] rr, ex_x, ex_y;

    always_comb begin
        kind_sel = kind_q;
        opnd     = 8'h00;
        case (state_q)
            S_IDLE:   begin kind_sel = dec_kind; opnd = rf_view[in_data[2:0]]; end
            S_PREFIX: begin kind_sel = K_CB;     opnd = rf_view[in_data[2:0]]; end
            S_IMM:    opnd = in_data;
            S_MEMRD:  opnd = mem_rdata;
            default:  ;
        endcase
        case (in_data[5:4])
            2'd0:    rr = {b_q, c_q};
            2'd1:    rr = {d_q, e_q};
            2'd2:    rr = hl_w;
            default: rr = sp_in;
        endcase
        case (kind_sel)
            K_G1:    begin ex_x = {8'h00, a_q}; ex_y = {8'h00, opnd}; end
            K_ACC:   begin ex_x = {8'h00, a_q}; ex_y = 16'h0000;      end
            K_ADD16: begin ex_x = hl_w;         ex_y = rr;            end
            default: begin ex_x = {8'h00, opnd}; ex_y = 16'h0000;     end
        endcase
    end

    // ---------------- commit decode (used in EXEC) ----------------
    logic [7:0] res8;
    logic       is_bit, is_rs, wr_en, wr_hl, to_memwr;
    logic [2:0] wr_idx;
    logic [3:0] f_d;

    assign res8   = alu_o[7:0];
    assign is_bit = (op_q[7:4] == 4'h3);
    assign is_rs  = (op_q[7:4] == 4'h4) || (op_q[7:4] == 4'h5);

    always_comb begin
        wr_en    = 1'b0;
        wr_idx   = src_q;
        wr_hl    = 1'b0;
        to_memwr = 1'b0;
        f_d      = alu_fout;
        case (kind_q)
            K_G1: begin
                wr_en  = (op_q[2:0] != 3'd7);   // CP only sets flags
                wr_idx = IDX_A;
            end
            K_ACC: begin
                // SCF/CCF only touch flags; A is left alone.
                wr_en  = (op_q[2:1] != 2'b11);
                wr_idx = IDX_A;
                case (op_q[2:0])
                    3'd0, 3'd1, 3'd2, 3'd3: f_d = {1'b0, alu_fout[2:0]};
                    3'd4: f_d = {(res8 == 8'h00), alu_fout[2], 1'b0, alu_fout[0]};
                    3'd5: f_d = {alu_fout[3], 2'b11, alu_fout[0]};
                    default: ;
                endcase
            end
            K_ADD16: wr_hl = 1'b1;
            default: begin
                if (is_rs)
                    f_d = f_q;
                if (!is_bit) begin
                    if (src_q == IDX_HL) to_memwr = 1'b1;
                    else                 wr_en    = 1'b1;
                end
            end
        endcase
    end

    // ---------------- main FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            kind_q    <= K_G1;
            src_q     <= 3'd0;
            op_q      <= 8'h00;
            x_q       <= 16'h0000;
            y_q       <= 16'h0000;
            wdata_q   <= 8'h00;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            a_q       <= RESET_AF[15:8];
            f_q       <= RESET_AF[7:4];
            b_q       <= RESET_BC[15:8];
            c_q       <= RESET_BC[7:0];
            d_q       <= RESET_DE[15:8];
            e_q       <= RESET_DE[7:0];
            h_q       <= RESET_HL[15:8];
            l_q       <= RESET_HL[7:0];
        end else begin
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            case (state_q)
                S_IDLE, S_PREFIX: begin
                    if (accept) begin
                        if (dec_ill) begin
                            illegal_q <= 1'b1;
                        end else begin
                            kind_q  <= dec_kind;
                            src_q   <= in_data[2:0];
                            state_q <= dec_next;
                            if (dec_next != S_PREFIX)
                                op_q <= dec_op;
                            if (dec_next == S_EXEC) begin
                                x_q <= ex_x;
                                y_q <= ex_y;
                            end
                        end
                    end
                end
                S_IMM: begin
                    if (accept) begin
                        x_q     <= ex_x;
                        y_q     <= ex_y;
                        state_q <= S_EXEC;
                    end
                end
                S_MEMRD: begin
                    if (mem_ack) begin
                        x_q     <= ex_x;
                        y_q     <= ex_y;
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    f_q <= f_d;
                    if (wr_en) begin
                        case (wr_idx)
                            3'd0: b_q <= res8;
                            3'd1: c_q <= res8;
                            3'd2: d_q <= res8;
                            3'd3: e_q <= res8;
                            3'd4: h_q <= res8;
                            3'd5: l_q <= res8;
                            3'd7: a_q <= res8;
                            default: ;
                        endcase
                    end
                    if (wr_hl) begin
                        h_q <= alu_o[15:8];
                        l_q <= alu_o[7:0];
                    end
                    if (to_memwr) begin
                        wdata_q <= res8;
                        state_q <= S_MEMWR;
                    end else begin
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                S_MEMWR: begin
                    if (mem_ack) begin
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    logic trap_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            trap_q <= 1'b0;
        else if (state_q == S_IDLE && accept && dec_ill)
            trap_q <= 1'b1;
    end
    assign trap_w = trap_q;
`else
    assign trap_w = 1'b0;
`endif

    // HL cannot change while a request is outstanding, so addr is stable.
    assign mem_req   = (state_q == S_MEMRD) || (state_q == S_MEMWR);
    assign mem_we    = (state_q == S_MEMWR);
    assign mem_addr  = hl_w;
    assign mem_wdata = wdata_q;
    assign alu_op    = op_q;
    assign alu_x     = x_q;
    assign alu_y     = y_q;
    assign alu_fin   = f_q;
    assign done      = done_q;
    assign illegal   = illegal_q;
    assign trap      = trap_w;
    assign reg_af    = {a_q, f_q, 4'h0};
    assign reg_bc    = {b_q, c_q};
    assign reg_de    = {d_q, e_q};
    assign reg_hl    = hl_w;

endmodule

// File: tb/tb_alu_issue_unit.sv
module tb_alu_issue_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic [15:0] sp_in = 16'h0000;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ack = 1'b0;
    logic [7:0]  mem_rdata = 8'h00;
    logic [7:0]  alu_op;
    logic [15:0] alu_x, alu_y;
    logic [3:0]  alu_fin;
    logic [15:0] alu_o = 16'h0000;
    logic [3:0]  alu_fout = 4'h0;
    logic        done, illegal, trap;
    logic [15:0] reg_af, reg_bc, reg_de, reg_hl;

    int checks = 0;
    int errors = 0;

    alu_issue_unit dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .sp_in(sp_in),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .alu_op(alu_op), .alu_x(alu_x), .alu_y(alu_y), .alu_fin(alu_fin),
        .alu_o(alu_o), .alu_fout(alu_fout),
        .done(done), .illegal(illegal), .trap(trap),
        .reg_af(reg_af), .reg_bc(reg_bc), .reg_de(reg_de), .reg_hl(reg_hl)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        mem_ack = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Presents a byte and returns 1ns after the edge that accepted it.
    task automatic put_byte(input logic [7:0] b);
        int n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=in_ready0 required=in_ready1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    typedef struct {
        logic [7:0]  b0, b1;
        bit          two;
        logic [15:0] sp, o;
        logic [3:0]  fo;
        logic [7:0]  eop;
        logic [15:0] ex, ey, eaf, ebc, ede, ehl;
    } vec_t;

    vec_t vt[14];

    initial begin
        //        b0     b1     two  sp        alu_o     fout  op     x         y         AF        BC        DE        HL
        vt[0]  = '{8'hC6, 8'hFF, 1'b1, 16'h0000, 16'h0100, 4'hB, 8'h00, 16'h0001, 16'h00FF, 16'h00B0, 16'h0013, 16'h00D8, 16'h014D};
        vt[1]  = '{8'hCB, 8'h37, 1'b1, 16'h0000, 16'h0010, 4'h0, 8'h27, 16'h0001, 16'h0000, 16'h1000, 16'h0013, 16'h00D8, 16'h014D};
        vt[2]  = '{8'h09, 8'h00, 1'b0, 16'h0000, 16'h0160, 4'h8, 8'h20, 16'h014D, 16'h0013, 16'h0180, 16'h0013, 16'h00D8, 16'h0160};
        vt[3]  = '{8'h80, 8'h00, 1'b0, 16'h0000, 16'h0001, 4'h0, 8'h00, 16'h0001, 16'h0000, 16'h0100, 16'h0013, 16'h00D8, 16'h014D};
        vt[4]  = '{8'hB9, 8'h00, 1'b0, 16'h0000, 16'h00EE, 4'h5, 8'h07, 16'h0001, 16'h0013, 16'h0150, 16'h0013, 16'h00D8, 16'h014D};
        vt[5]  = '{8'h07, 8'h00, 1'b0, 16'h0000, 16'h0002, 4'h8, 8'h10, 16'h0001, 16'h0000, 16'h0200, 16'h0013, 16'h00D8, 16'h014D};
        vt[6]  = '{8'h27, 8'h00, 1'b0, 16'h0000, 16'h0000, 4'h6, 8'h14, 16'h0001, 16'h0000, 16'h00C0, 16'h0013, 16'h00D8, 16'h014D};
        vt[7]  = '{8'h2F, 8'h00, 1'b0, 16'h0000, 16'h00FE, 4'h0, 8'h15, 16'h0001, 16'h0000, 16'hFE60, 16'h0013, 16'h00D8, 16'h014D};
        vt[8]  = '{8'hCB, 8'h11, 1'b1, 16'h0000, 16'h0026, 4'h0, 8'h12, 16'h0013, 16'h0000, 16'h0100, 16'h0026, 16'h00D8, 16'h014D};
        vt[9]  = '{8'hCB, 8'h7B, 1'b1, 16'h0000, 16'h00D8, 4'h2, 8'h37, 16'h00D8, 16'h0000, 16'h0120, 16'h0013, 16'h00D8, 16'h014D};
        vt[10] = '{8'hCB, 8'hDA, 1'b1, 16'h0000, 16'h0008, 4'hF, 8'h53, 16'h0000, 16'h0000, 16'h01B0, 16'h0013, 16'h08D8, 16'h014D};
        vt[11] = '{8'hCB, 8'h84, 1'b1, 16'h0000, 16'h0000, 4'h0, 8'h40, 16'h0001, 16'h0000, 16'h01B0, 16'h0013, 16'h00D8, 16'h004D};
        vt[12] = '{8'h39, 8'h00, 1'b0, 16'hFFFE, 16'h014B, 4'h3, 8'h20, 16'h014D, 16'hFFFE, 16'h0130, 16'h0013, 16'h00D8, 16'h014B};
        vt[13] = '{8'hE6, 8'h0F, 1'b1, 16'h0000, 16'h0001, 4'h2, 8'h04, 16'h0001, 16'h000F, 16'h0120, 16'h0013, 16'h00D8, 16'h014D};

        // ---- reset state ----
        repeat (2) @(negedge clk);
        chk("rst_ready", in_ready, 1);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_done", done, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_trap", trap, 0);
        chk("rst_alu_op", alu_op, 8'h00);
        chk("rst_alu_x", alu_x, 0);
        chk("rst_alu_y", alu_y, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_af", reg_af, 16'h01B0);
        chk("rst_bc", reg_bc, 16'h0013);
        chk("rst_de", reg_de, 16'h00D8);
        chk("rst_hl", reg_hl, 16'h014D);
        chk("rst_fin", alu_fin, 4'hB);

        // ---- table-driven register/immediate ops ----
        for (int i = 0; i < 14; i++) begin
            sp_in    = vt[i].sp;
            alu_o    = vt[i].o;
            alu_fout = vt[i].fo;
            do_reset();
            put_byte(vt[i].b0);
            if (vt[i].two) put_byte(vt[i].b1);
            @(negedge clk);
            chk($sformatf("v%0d_op", i), alu_op, vt[i].eop);
            chk($sformatf("v%0d_x", i), alu_x, vt[i].ex);
            chk($sformatf("v%0d_y", i), alu_y, vt[i].ey);
            chk($sformatf("v%0d_done_early", i), done, 0);
            @(negedge clk);
            chk($sformatf("v%0d_done", i), done, 1);
            chk($sformatf("v%0d_af", i), reg_af, vt[i].eaf);
            chk($sformatf("v%0d_bc", i), reg_bc, vt[i].ebc);
            chk($sformatf("v%0d_de", i), reg_de, vt[i].ede);
            chk($sformatf("v%0d_hl", i), reg_hl, vt[i].ehl);
            @(negedge clk);
            chk($sformatf("v%0d_done_pulse", i), done, 0);
        end

        // ---- SET 0,(HL): read with delayed ack, then write ----
        alu_o = 16'h0041;
        alu_fout = 4'h0;
        mem_rdata = 8'h40;
        do_reset();
        put_byte(8'hCB);
        put_byte(8'hC6);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rd_req", mem_req, 1);
            chk("rd_we", mem_we, 0);
            chk("rd_addr", mem_addr, 16'h014D);
            chk("rd_ready", in_ready, 0);
        end
        mem_ack = 1'b1;
        @(posedge clk);
        #1 mem_ack = 1'b0;
        mem_rdata = 8'h00;
        @(negedge clk);
        chk("hl_exec_op", alu_op, 8'h50);
        chk("hl_exec_x", alu_x, 16'h0040);
        chk("hl_exec_req", mem_req, 0);
        @(negedge clk);
        chk("wr_req", mem_req, 1);
        chk("wr_we", mem_we, 1);
        chk("wr_addr", mem_addr, 16'h014D);
        chk("wr_data", mem_wdata, 8'h41);
        chk("wr_done_early", done, 0);
        mem_ack = 1'b1;
        @(posedge clk);
        #1 mem_ack = 1'b0;
        @(negedge clk);
        chk("hl_done", done, 1);
        chk("hl_req_off", mem_req, 0);
        chk("hl_af", reg_af, 16'h01B0);
        chk("hl_hl", reg_hl, 16'h014D);

        // ---- illegal byte ----
        do_reset();
        put_byte(8'h00);
        @(negedge clk);
        chk("ill_pulse", illegal, 1);
        chk("ill_done", done, 0);
        chk("ill_af", reg_af, 16'h01B0);
        chk("ill_bc", reg_bc, 16'h0013);
        chk("ill_de", reg_de, 16'h00D8);
        chk("ill_hl", reg_hl, 16'h014D);
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
        chk("ill_trap", trap, 1);
        chk("ill_ready", in_ready, 0);
        repeat (3) @(negedge clk);
        chk("ill_ready_held", in_ready, 0);
        chk("ill_trap_held", trap, 1);
        rst_n = 1'b0;
        #1;
        chk("ill_trap_clr", trap, 0);
        chk("ill_ready_rst", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
`else
        chk("ill_trap", trap, 0);
        chk("ill_ready", in_ready, 1);
`endif
        @(negedge clk);
        chk("ill_pulse_end", illegal, 0);

        // ---- reset during MEMRD aborts and restores ----
        alu_o = 16'h00FE;
        alu_fout = 4'h0;
        do_reset();
        put_byte(8'h2F);
        repeat (2) @(negedge clk);
        chk("ab_pre_af", reg_af, 16'hFE60);
        put_byte(8'h86);
        @(negedge clk);
        chk("ab_req", mem_req, 1);
        rst_n = 1'b0;
        #1;
        chk("ab_req_drop", mem_req, 0);
        chk("ab_ready", in_ready, 1);
        chk("ab_af", reg_af, 16'h01B0);
        chk("ab_op", alu_op, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("ab_no_done", done, 0);
        chk("ab_idle_req", mem_req, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
